cv32e40x_mult_iter: RTL and testbench
=====================================

# cv32e40x_mult_iter

Parametrised successor of the core's integer multiplier, sitting in the EX stage beside the ALU. It executes low-half multiply (MUL) and high-half multiplies (MULH/MULHSU/MULHU) for a configurable data width XLEN. MULH is computed either iteratively over four half-width partial-product phases or in a single cycle, selected by parameter. It keeps the EX-stage valid/ready handshake with halt and kill semantics.

## Interface
- XLEN, 32, operand/result width; legal values 32 and 64. H = XLEN/2.
- SINGLE_CYCLE_MULH, 0; 0 = four-phase iterative MULH, 1 = MULH completes in one cycle using a full 2·XLEN-bit product.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- valid_i  in  1  operation present in EX.
- halt_i  in  1  EX stage halted; freezes the FSM and accumulator.
- operator_i  in  mul_opcode_e  MUL_M32 = low-half product; MUL_H = high-half product.
- signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed. MULH = 11, MULHSU = 01, MULHU = 00.
- op_a_i, op_b_i  in  XLEN  operands; must stay stable while a MULH is in progress.
- result_o  out  XLEN  result; meaningful only when valid_o = 1.
- valid_o  out  1  result_o valid this cycle.
- ready_o  out  1  the block releases the instruction this cycle.
- ready_i  in  1  downstream accepts the result.
- busy_o  out  1  iterative MULH is past phase ALBL (state != ALBL).

## Operation
- Operand halves:
  - al = {1'b0, a[H-1:0]} and bl = {1'b0, b[H-1:0]}.
  - ah = {sa & a[XLEN-1], a[XLEN-1:H]} and bh = {sb & b[XLEN-1], b[XLEN-1:H]}.
  - All four are H+1 bits and are treated as signed.
- MUL_M32: result_o = (op_a_i · op_b_i)[XLEN-1:0]. signed_mode_i is ignored. Completes in the same cycle.
- SINGLE_CYCLE_MULH = 1:
  - Product P = ext(op_a_i) · ext(op_b_i), 2·XLEN bits, where each operand is sign-extended per signed_mode_i.
  - result_o = P[2·XLEN-1:XLEN]. Completes in the same cycle. The FSM stays in ALBL.
- SINGLE_CYCLE_MULH = 0: four-state FSM with states ALBL, ALBH, AHBL, AHBH and an accumulator acc of XLEN+1 bits (signed).
  - ALBL: acc ← (al·bl) >>> H. Go to ALBH.
  - ALBH: acc ← acc + al·bh. Go to AHBL.
  - AHBL: acc ← (acc + ah·bl) >>> H. Go to AHBH.
  - AHBH: result_o = (acc + ah·bh)[XLEN-1:0] and valid_o = 1.
    - If ready_i = 1: ready_o = 1, acc ← 0, state ← ALBL.
    - If ready_i = 0: hold state and acc.
- Width rule: every partial product is a signed (H+1)×(H+1) product. The sum is formed at XLEN+2 bits before any shift or truncation, so no intermediate overflows.
- In ALBL with MUL_M32, or with MULH when SINGLE_CYCLE_MULH = 1:
  - valid_o = 1.
  - ready_o = ready_i.
- Kill: if valid_i = 0 and halt_i = 0 in any state:
  - state ← ALBL and acc ← 0.
  - ready_o = 1 and valid_o = 0.
- Halt: if halt_i = 1, state and acc hold. Outputs follow the current-state rules; valid_i = 0 is then not a kill.
- Reset: state = ALBL, acc = 0.

## Timing
- After reset with valid_i = 0: valid_o = 0, ready_o = 1, busy_o = 0, result_o = 0.
- Latency, first valid_o measured from the cycle valid_i rises:
  - MUL: 0 cycles.
  - MULH, single-cycle mode: 0 cycles.
  - MULH, iterative mode: 3 cycles. Results appear in the 4th cycle of occupancy.
- While ready_i = 0, valid_o and result_o hold stable.
- Back-to-back MULH: the next op enters ALBL in the cycle after the AHBH handshake. No bubble is inserted by the block.
- Kill beats everything except halt, including a simultaneous ready_i in AHBH.
- A kill in the same cycle as a new MULH start aborts that start. busy_o stays 0.
- Reset asserted mid-MULH: the next cycle is in ALBL with acc = 0, and no valid_o is produced for the aborted op.

## Test plan
- XLEN=32, MUL_M32, a = 7, b = 6 → valid_o and ready_o in the same cycle, result_o = 0x0000002A. Also a = 0xFFFFFFFF, b = 2 → 0xFFFFFFFE.
- XLEN=32, iterative, MULH (mode 11), a = b = 0x80000000 → valid_o on cycle 4, result_o = 0x40000000. Also MULHU (mode 00), a = b = 0xFFFFFFFF → 0xFFFFFFFE. Also MULHSU (mode 01), a = b = 0xFFFFFFFF → 0xFFFFFFFF.
- Backpressure: hold ready_i = 0 for 3 cycles in AHBH → valid_o and result_o stay stable and ready_o = 0. On ready_i = 1, ready_o = 1 and the next cycle has busy_o = 0.
- Kill and halt during a MULH:
  - Drop valid_i with halt_i = 0 while in AHBL → same cycle ready_o = 1 and valid_o = 0. Next cycle state is ALBL, and a following MULHU 3 × 5 returns 0.
  - Repeat with halt_i = 1 → state is frozen; resuming completes with the correct result.
- Synchronous reset asserted in ALBH → next cycle busy_o = 0 and valid_o = 0 with valid_i = 0.
- SINGLE_CYCLE_MULH=1, XLEN=64, MULHU, a = 2^63, b = 4 → same-cycle valid_o, result_o = 2. In iterative XLEN=64, the same op gives result_o = 2 on cycle 4.

Source files
------------

// File: rtl/cv32e40x_mult_iter_if.sv
// Operator encoding and the EX-stage handshake bundle for cv32e40x_mult_iter.
// The master side is the EX stage driving operands; the slave side is the multiplier.
package cv32e40x_mult_pkg;
  typedef enum logic {
    MUL_M32 = 1'b0,
    MUL_H   = 1'b1
  } mul_opcode_e;
endpackage

interface cv32e40x_mult_iter_if #(
  parameter int XLEN = 32
);
  import cv32e40x_mult_pkg::*;

  logic            valid_i;
  logic            halt_i;
  mul_opcode_e     operator_i;
  logic [1:0]      signed_mode_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic [XLEN-1:0] result_o;
  logic            valid_o;
  logic            ready_o;
  logic            ready_i;
  logic            busy_o;

  modport master (
    output valid_i, halt_i, operator_i, signed_mode_i, op_a_i, op_b_i, ready_i,
    input  result_o, valid_o, ready_o, busy_o
  );

  modport slave (
    input  valid_i, halt_i, operator_i, signed_mode_i, op_a_i, op_b_i, ready_i,
    output result_o, valid_o, ready_o, busy_o
  );
endinterface

// File: rtl/cv32e40x_mult_iter.sv
// EX-stage integer multiplier: single-cycle MUL, and MULH either single-cycle or
// iterated over four half-width partial products with a signed accumulator.
module cv32e40x_mult_iter
  import cv32e40x_mult_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter bit SINGLE_CYCLE_MULH = 1'b0
) (
  input logic               clk,
  input logic               rst,
  cv32e40x_mult_iter_if.slave mif
);
  localparam int H = XLEN / 2;

  typedef enum logic [1:0] {
    ALBL = 2'd0,
    ALBH = 2'd1,
    AHBL = 2'd2,
    AHBH = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic signed [XLEN:0]   acc_q, acc_d;

  logic                   sa, sb;
  logic signed [H:0]      al, ah, bl, bh;
  logic signed [H:0]      pp_a, pp_b;
  logic signed [XLEN+1:0] pp, acc_term, sum;
  logic [XLEN-1:0]        mul_lo, mulh_sc;

  logic                   res_valid, res_ready;
  logic [XLEN-1:0]        res_data;
  logic                   kill;

  assign sa = mif.signed_mode_i[0];
  assign sb = mif.signed_mode_i[1];

  // Low halves are always non-negative; high halves carry the operand sign bit when signed.
  assign al = {1'b0, mif.op_a_i[H-1:0]};
  assign bl = {1'b0, mif.op_b_i[H-1:0]};
  assign ah = {sa & mif.op_a_i[XLEN-1], mif.op_a_i[XLEN-1:H]};
  assign bh = {sb & mif.op_b_i[XLEN-1], mif.op_b_i[XLEN-1:H]};

  assign pp_a     = (state_q == ALBL || state_q == ALBH) ? al : ah;
  assign pp_b     = (state_q == ALBL || state_q == AHBL) ? bl : bh;
  assign pp       = {{(H+1){pp_a[H]}}, pp_a} * {{(H+1){pp_b[H]}}, pp_b};
  assign acc_term = (state_q == ALBL) ? '0 : {acc_q[XLEN], acc_q};
  // Two guard bits above the accumulator keep every add exact before shift/truncate.
  assign sum      = acc_term + pp;

  if (SINGLE_CYCLE_MULH) begin : g_sc
    logic signed [2*XLEN-1:0] a_ext, b_ext, prod;
    assign a_ext   = {{XLEN{sa & mif.op_a_i[XLEN-1]}}, mif.op_a_i};
    assign b_ext   = {{XLEN{sb & mif.op_b_i[XLEN-1]}}, mif.op_b_i};
    assign prod    = a_ext * b_ext;
    assign mul_lo  = prod[XLEN-1:0];
    assign mulh_sc = prod[2*XLEN-1:XLEN];
  end else begin : g_iter
    assign mul_lo  = mif.op_a_i * mif.op_b_i;
    assign mulh_sc = '0;
  end

  assign kill = !mif.valid_i && !mif.halt_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALBL;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    res_valid = 1'b0;
    res_ready = 1'b0;
    res_data  = '0;

    case (state_q)
      ALBL: begin
        if (mif.operator_i == MUL_M32 || SINGLE_CYCLE_MULH) begin
          res_valid = mif.valid_i;
          res_ready = mif.ready_i;
          res_data  = (mif.operator_i == MUL_M32) ? mul_lo : mulh_sc;
        end else if (mif.valid_i && !mif.halt_i) begin
          acc_d   = (XLEN+1)'(sum >>> H);
          state_d = ALBH;
        end
      end
      ALBH: begin
        if (!mif.halt_i) begin
          acc_d   = sum[XLEN:0];
          state_d = AHBL;
        end
      end
      AHBL: begin
        if (!mif.halt_i) begin
          acc_d   = (XLEN+1)'(sum >>> H);
          state_d = AHBH;
        end
      end
      AHBH: begin
        res_valid = 1'b1;
        res_data  = sum[XLEN-1:0];
        if (mif.ready_i) begin
          res_ready = 1'b1;
          if (!mif.halt_i) begin
            acc_d   = '0;
            state_d = ALBL;
          end
        end
      end
      default: state_d = ALBL;
    endcase

    // Dropping valid without a halt aborts whatever is in flight, even a completing AHBH.
    if (kill) begin
      state_d   = ALBL;
      acc_d     = '0;
      res_valid = 1'b0;
      res_ready = 1'b1;
      res_data  = '0;
    end
  end

  assign mif.valid_o  = res_valid;
  assign mif.ready_o  = res_ready;
  assign mif.result_o = res_data;
  assign mif.busy_o   = (state_q != ALBL);
endmodule

// File: tb/tb_cv32e40x_mult_iter.sv
// Directed bench for cv32e40x_mult_iter: 32-bit iterative, 64-bit single-cycle and
// 64-bit iterative instances checked against a scoreboard of reference products.
module tb_cv32e40x_mult_iter;
  import cv32e40x_mult_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cv32e40x_mult_iter_if #(.XLEN(32)) m32 ();
  cv32e40x_mult_iter_if #(.XLEN(64)) m64s ();
  cv32e40x_mult_iter_if #(.XLEN(64)) m64i ();

  cv32e40x_mult_iter #(.XLEN(32), .SINGLE_CYCLE_MULH(1'b0)) u32 (
    .clk(clk), .rst(rst), .mif(m32)
  );
  cv32e40x_mult_iter #(.XLEN(64), .SINGLE_CYCLE_MULH(1'b1)) u64s (
    .clk(clk), .rst(rst), .mif(m64s)
  );
  cv32e40x_mult_iter #(.XLEN(64), .SINGLE_CYCLE_MULH(1'b0)) u64i (
    .clk(clk), .rst(rst), .mif(m64i)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t q32[$];
  exp_t q64s[$];
  exp_t q64i[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model32(input mul_opcode_e op, input logic [1:0] md,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {{32{md[0] & a[31]}}, a};
    eb = {{32{md[1] & b[31]}}, b};
    p  = ea * eb;
    return (op == MUL_H) ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [63:0] model64(input mul_opcode_e op, input logic [1:0] md,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = {{64{md[0] & a[63]}}, a};
    eb = {{64{md[1] & b[63]}}, b};
    p  = ea * eb;
    return (op == MUL_H) ? p[127:64] : p[63:0];
  endfunction

  task automatic drive32(input logic v, input mul_opcode_e op, input logic [1:0] md,
                         input logic [31:0] a, input logic [31:0] b);
    m32.valid_i       = v;
    m32.operator_i    = op;
    m32.signed_mode_i = md;
    m32.op_a_i        = a;
    m32.op_b_i        = b;
  endtask

  task automatic drive64(input logic v, input mul_opcode_e op, input logic [1:0] md,
                         input logic [63:0] a, input logic [63:0] b);
    m64s.valid_i = v; m64s.operator_i = op; m64s.signed_mode_i = md;
    m64s.op_a_i  = a; m64s.op_b_i     = b;
    m64i.valid_i = v; m64i.operator_i = op; m64i.signed_mode_i = md;
    m64i.op_a_i  = a; m64i.op_b_i     = b;
  endtask

  // Drives one op on the 32-bit DUT with ready_i = 1 and waits (bounded) for valid_o.
  task automatic do_op32(input string tag, input mul_opcode_e op, input logic [1:0] md,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
    exp_t e;
    int   got;
    got = -1;
    drive32(1'b1, op, md, a, b);
    q32.push_back('{res: 64'(res), lat: lat});
    for (int k = 0; k < 8; k++) begin
      #1;
      if (m32.valid_o === 1'b1) begin
        got = k;
        break;
      end
      cyc();
    end
    e = q32.pop_front();
    chk({tag, "_lat"}, 64'(got), 64'(e.lat));
    if (got >= 0) begin
      chk({tag, "_res"}, 64'(m32.result_o), e.res);
      chk({tag, "_rdy"}, 64'(m32.ready_o), 64'd1);
    end
    $display("[%0t] %s op=%0d mode=%b a=%h b=%h result=%h latency=%0d",
             $time, tag, op, md, a, b, m32.result_o, got);
    cyc();
    chk({tag, "_idle"}, 64'(m32.busy_o), 64'd0);
  endtask

  task automatic do_op64(input string tag, input mul_opcode_e op, input logic [1:0] md,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] res);
    exp_t e;
    int   got;
    got = -1;
    drive64(1'b1, op, md, a, b);
    q64s.push_back('{res: res, lat: 0});
    q64i.push_back('{res: res, lat: (op == MUL_H) ? 3 : 0});
    #1;
    e = q64s.pop_front();
    chk({tag, "_sc_valid"}, 64'(m64s.valid_o), 64'd1);
    chk({tag, "_sc_res"}, m64s.result_o, e.res);
    chk({tag, "_sc_busy"}, 64'(m64s.busy_o), 64'd0);
    for (int k = 0; k < 8; k++) begin
      if (m64i.valid_o === 1'b1) begin
        got = k;
        break;
      end
      cyc();
      #1;
    end
    e = q64i.pop_front();
    chk({tag, "_it_lat"}, 64'(got), 64'(e.lat));
    chk({tag, "_it_res"}, m64i.result_o, e.res);
    $display("[%0t] %s op=%0d mode=%b a=%h b=%h sc=%h it=%h latency=%0d",
             $time, tag, op, md, a, b, m64s.result_o, m64i.result_o, got);
    cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: summary not reached in time");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t        e;
    logic [31:0] ra, rb;
    logic [63:0] wa, wb;
    logic [1:0]  rm;
    mul_opcode_e rop;
    int          got;

    drive32(1'b0, MUL_M32, 2'b00, '0, '0);
    m32.halt_i  = 1'b0;
    m32.ready_i = 1'b1;
    drive64(1'b0, MUL_M32, 2'b00, '0, '0);
    m64s.halt_i = 1'b0; m64s.ready_i = 1'b1;
    m64i.halt_i = 1'b0; m64i.ready_i = 1'b1;

    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(m32.valid_o), 64'd0);
    chk("rst_ready", 64'(m32.ready_o), 64'd1);
    chk("rst_busy", 64'(m32.busy_o), 64'd0);
    chk("rst_result", 64'(m32.result_o), 64'd0);
    chk("rst_ready_64s", 64'(m64s.ready_o), 64'd1);
    chk("rst_busy_64i", 64'(m64i.busy_o), 64'd0);
    cyc();

    do_op32("mul_7x6", MUL_M32, 2'b00, 32'd7, 32'd6, 32'h0000_002A, 0);
    do_op32("mul_neg1x2", MUL_M32, 2'b11, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0);
    do_op32("mulh_min", MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3);
    do_op32("mulhu_max", MUL_H, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
    do_op32("mulhsu_max", MUL_H, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);

    for (int i = 0; i < 8; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rm  = 2'($urandom_range(0, 3));
      rop = (i % 3 == 0) ? MUL_M32 : MUL_H;
      do_op32($sformatf("rnd%0d", i), rop, rm, ra, rb, model32(rop, rm, ra, rb),
              (rop == MUL_H) ? 3 : 0);
    end
    m32.valid_i = 1'b0;
    cyc();

    // Backpressure in AHBH: result must hold until ready_i returns.
    drive32(1'b1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000);
    m32.ready_i = 1'b0;
    q32.push_back('{res: 64'h4000_0000, lat: 3});
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_wait%0d", k), 64'(m32.valid_o), 64'd0);
      cyc();
    end
    e = q32.pop_front();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_hold_valid%0d", k), 64'(m32.valid_o), 64'd1);
      chk($sformatf("bp_hold_res%0d", k), 64'(m32.result_o), e.res);
      chk($sformatf("bp_hold_rdy%0d", k), 64'(m32.ready_o), 64'd0);
      cyc();
    end
    m32.ready_i = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(m32.ready_o), 64'd1);
    chk("bp_release_res", 64'(m32.result_o), e.res);
    $display("[%0t] backpressure mulh result=%h", $time, m32.result_o);
    cyc();
    m32.valid_i = 1'b0;
    #1;
    chk("bp_after_busy", 64'(m32.busy_o), 64'd0);
    cyc();

    // Kill in AHBL.
    drive32(1'b1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000);
    cyc();
    cyc();
    #1;
    chk("kill_pre_busy", 64'(m32.busy_o), 64'd1);
    m32.valid_i = 1'b0;
    #1;
    chk("kill_ready", 64'(m32.ready_o), 64'd1);
    chk("kill_valid", 64'(m32.valid_o), 64'd0);
    cyc();
    chk("kill_after_busy", 64'(m32.busy_o), 64'd0);
    do_op32("kill_next", MUL_H, 2'b00, 32'd3, 32'd5, 32'd0, 3);
    m32.valid_i = 1'b0;
    cyc();

    // Halt in AHBL with valid dropped: frozen, then resumes to the right answer.
    drive32(1'b1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000);
    cyc();
    cyc();
    m32.halt_i  = 1'b1;
    m32.valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("halt_busy%0d", k), 64'(m32.busy_o), 64'd1);
      chk($sformatf("halt_valid%0d", k), 64'(m32.valid_o), 64'd0);
      cyc();
    end
    m32.halt_i  = 1'b0;
    m32.valid_i = 1'b1;
    q32.push_back('{res: 64'h4000_0000, lat: 1});
    got = -1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (m32.valid_o === 1'b1) begin
        got = k;
        break;
      end
      cyc();
    end
    e = q32.pop_front();
    chk("halt_resume_lat", 64'(got), 64'(e.lat));
    chk("halt_resume_res", 64'(m32.result_o), e.res);
    $display("[%0t] halted mulh result=%h latency=%0d", $time, m32.result_o, got);
    cyc();
    m32.valid_i = 1'b0;
    cyc();

    // Reset in ALBH while halted must still return to idle.
    drive32(1'b1, MUL_H, 2'b11, 32'h8000_0000, 32'h8000_0000);
    cyc();
    #1;
    chk("rst_mid_pre_busy", 64'(m32.busy_o), 64'd1);
    rst         = 1'b1;
    m32.halt_i  = 1'b1;
    cyc();
    rst         = 1'b0;
    m32.halt_i  = 1'b0;
    m32.valid_i = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(m32.busy_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_mid_valid%0d", k), 64'(m32.valid_o), 64'd0);
      cyc();
    end
    $display("[%0t] reset mid-mulh aborted", $time);

    do_op64("w_mulhu_2p63x4", MUL_H, 2'b00, 64'h8000_0000_0000_0000, 64'd4, 64'd2);
    do_op64("w_mulh_m1xm1", MUL_H, 2'b11, '1, '1, 64'd0);
    do_op64("w_mulhsu_m1x2", MUL_H, 2'b01, '1, 64'd2, '1);
    do_op64("w_mul_m1x3", MUL_M32, 2'b00, '1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD);
    for (int i = 0; i < 4; i++) begin
      wa  = {$urandom, $urandom};
      wb  = {$urandom, $urandom};
      rm  = 2'($urandom_range(0, 3));
      rop = (i == 3) ? MUL_M32 : MUL_H;
      do_op64($sformatf("w_rnd%0d", i), rop, rm, wa, wb, model64(rop, rm, wa, wb));
    end
    drive64(1'b0, MUL_M32, 2'b00, '0, '0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
